// File: rtl/pc_unit_ras.sv
// Program-counter unit with stall, instruction-window wrap and a return-address stack.
// pc_addr is the registered fetch address; every next-PC decision is made from the
// current inputs and lands on the following rising clkin edge.
module pc_unit_ras #(
  parameter int              AW         = 32,
  parameter longint unsigned IMEM_BYTES = 128,
  parameter logic [AW-1:0]   RESET_VEC  = '0,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          stall,
  input  logic          jump,
  input  logic          branch,
  input  logic          zero,
  input  logic          call,
  input  logic          ret,
  input  logic [31:0]   instr,
  input  logic [AW-1:0] rt_data,
  output logic [AW-1:0] pc_addr,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_err,
  output logic          oob
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  // ras_ptr is the next write slot; the most recent entry sits one below it.
  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;
  logic [CW-1:0] ras_cnt;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;
  logic [AW-1:0] ras_top;

  logic [AW-1:0] pc4;
  logic [AW-1:0] imm;
  logic [31:0]   pc4_ext;
  logic [31:0]   jmp_ext;
  logic [AW-1:0] jmp_tgt;
  logic [AW-1:0] target;
  logic [63:0]   tgt_ext;
  logic          is_jr;
  logic          do_pop;
  logic          do_push;
  logic          ras_under;
  logic          bad_align;
  logic          force_rst;

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_MAX);

  // Circular pointer arithmetic, valid for non-power-of-two depths too.
  always_comb begin
    ptr_inc = (ras_ptr == PTR_MAX) ? '0 : ras_ptr + 1'b1;
    ptr_dec = (ras_ptr == '0) ? PTR_MAX : ras_ptr - 1'b1;
    ras_top = ras_mem[ptr_dec];
  end

  // Candidate targets; the j/jal target is built 32 bits wide so AW = 28 needs no special case.
  always_comb begin
    pc4     = pc_addr + AW'(4);
    imm     = {{(AW-16){instr[15]}}, instr[15:0]};
    pc4_ext = '0;
    pc4_ext[AW-1:0] = pc4;
    jmp_ext = {pc4_ext[31:28], instr[25:0], 2'b00};
    jmp_tgt = jmp_ext[AW-1:0];
  end

  // Next-PC selection, RAS side effects and window check.
  always_comb begin
    is_jr     = jump & (instr[31:26] == 6'b001000);
    do_pop    = ~stall & is_jr & ret & ~ras_empty;
    do_push   = ~stall & jump & ~is_jr & call;
    ras_under = ~stall & is_jr & ret & ras_empty;
    bad_align = 1'b0;
    if (is_jr && ret && !ras_empty) begin
      target = ras_top;
    end else if (is_jr) begin
      target    = {rt_data[AW-1:2], 2'b00};
      bad_align = (rt_data[1:0] != 2'b00);
    end else if (jump) begin
      target = jmp_tgt;
    end else if (branch && zero) begin
      target = pc4 + (imm << 2);
    end else begin
      target = pc4;
    end
    tgt_ext = '0;
    tgt_ext[AW-1:0] = target;
    force_rst = bad_align | (tgt_ext >= IMEM_BYTES);
  end

  // PC register and the one-cycle out-of-window pulse.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pc_addr <= RESET_VEC;
      oob     <= 1'b0;
    end else if (stall) begin
      oob <= 1'b0;
    end else begin
      pc_addr <= force_rst ? RESET_VEC : target;
      oob     <= force_rst;
    end
  end

  // RAS pointer, saturating count and sticky error flag.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      ras_err <= 1'b0;
    end else begin
      if (do_push) begin
        ras_ptr <= ptr_inc;
        if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
      end else if (do_pop) begin
        ras_ptr <= ptr_dec;
        ras_cnt <= ras_cnt - 1'b1;
      end
      if (ras_under || (do_push && ras_full)) ras_err <= 1'b1;
    end
  end

  // RAS storage; a push when full lands on the oldest slot.
  always_ff @(posedge clkin) begin
    if (do_push) ras_mem[ras_ptr] <= pc4;
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras with default parameters
// (AW 32, 128-byte window, reset vector 0, 4-entry RAS).
module tb_pc_unit_ras;

  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, jump = 1'b0, branch = 1'b0, zero = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] instr = '0, rt_data = '0;
  logic [31:0] pc_addr;
  logic        ras_empty, ras_full, ras_err, oob;

  typedef struct packed {
    logic [31:0] pc;
    logic        oob;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_JR  = 6'b001000;

  pc_unit_ras dut (
    .clkin(clkin), .reset(reset), .stall(stall), .jump(jump), .branch(branch),
    .zero(zero), .call(call), .ret(ret), .instr(instr), .rt_data(rt_data),
    .pc_addr(pc_addr), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_err(ras_err), .oob(oob)
  );

  always #5 clkin = ~clkin;

  task automatic drive(input logic s, j, c, r, b, z, input logic [31:0] ins, rt);
    stall = s; jump = j; call = c; ret = r; branch = b; zero = z;
    instr = ins; rt_data = rt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic quiet_reset();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    quiet_reset();
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back('{pc: 32'(4*i), oob: 0, empty: 1, full: 0, err: 0});
      @(posedge clkin); #1;
      e = exp_q.pop_front(); n_chk++;
      if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
        $display("FAIL reset_pre%0d: got pc=%h flags=%b required pc=%h flags=%b", i, pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
      else n_pass++;
    end
    reset = 1'b1;
    exp_q.push_back('{pc: 32'h0, oob: 0, empty: 1, full: 0, err: 0});
    #2;
    e = exp_q.pop_front(); n_chk++;
    if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
      $display("FAIL reset_async: got pc=%h flags=%b required pc=%h flags=%b", pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
    else n_pass++;
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back('{pc: 32'(4*i), oob: 0, empty: 1, full: 0, err: 0});
      @(posedge clkin); #1;
      e = exp_q.pop_front(); n_chk++;
      if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
        $display("FAIL reset_seq%0d: got pc=%h flags=%b required pc=%h flags=%b", i, pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    logic [31:0] pcs [5] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h0C};
    logic [31:0] pcs2 [2] = '{32'h10, 32'h14};
    quiet_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) drive(0, 0, 0, 0, 1, 1, 32'h1000_FFFE, 32'h0);
      exp_q.push_back('{pc: pcs[i], oob: 0, empty: 1, full: 0, err: 0});
      @(posedge clkin); #1;
      e = exp_q.pop_front(); n_chk++;
      if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
        $display("FAIL branch_taken%0d: got pc=%h flags=%b required pc=%h flags=%b", i, pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 0) idle(); else drive(0, 0, 0, 0, 1, 0, 32'h1000_FFFE, 32'h0);
      exp_q.push_back('{pc: pcs2[i], oob: 0, empty: 1, full: 0, err: 0});
      @(posedge clkin); #1;
      e = exp_q.pop_front(); n_chk++;
      if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
        $display("FAIL branch_not_taken%0d: got pc=%h flags=%b required pc=%h flags=%b", i, pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_call_ret();
    quiet_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        2: drive(0, 1, 1, 0, 0, 0, {OP_JAL, 26'h10}, 32'h0);
        4: drive(0, 1, 0, 1, 0, 0, {OP_JR, 26'h0}, 32'h7C);
        default: idle();
      endcase
      case (i)
        0: exp_q.push_back('{pc: 32'h04, oob: 0, empty: 1, full: 0, err: 0});
        1: exp_q.push_back('{pc: 32'h08, oob: 0, empty: 1, full: 0, err: 0});
        2: exp_q.push_back('{pc: 32'h40, oob: 0, empty: 0, full: 0, err: 0});
        3: exp_q.push_back('{pc: 32'h44, oob: 0, empty: 0, full: 0, err: 0});
        default: exp_q.push_back('{pc: 32'h0C, oob: 0, empty: 1, full: 0, err: 0});
      endcase
      @(posedge clkin); #1;
      e = exp_q.pop_front(); n_chk++;
      if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
        $display("FAIL call_ret%0d: got pc=%h flags=%b required pc=%h flags=%b", i, pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_ras_overflow();
    quiet_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 0, 0, {OP_JAL, 26'(4*(i+1))}, 32'h0);
      exp_q.push_back('{pc: 32'(16*(i+1)), oob: 0, empty: 0, full: (i >= 3), err: (i == 4)});
      @(posedge clkin); #1;
      e = exp_q.pop_front(); n_chk++;
      if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
        $display("FAIL ras_push%0d: got pc=%h flags=%b required pc=%h flags=%b", i, pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
      else n_pass++;
    end
    for (int j = 0; j < 5; j++) begin
      drive(0, 1, 0, 1, 0, 0, {OP_JR, 26'h0}, (j == 4) ? 32'h60 : 32'h0);
      if (j < 4) exp_q.push_back('{pc: 32'(16*(4-j) + 4), oob: 0, empty: (j == 3), full: 0, err: 1});
      else       exp_q.push_back('{pc: 32'h60, oob: 0, empty: 1, full: 0, err: 1});
      @(posedge clkin); #1;
      e = exp_q.pop_front(); n_chk++;
      if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
        $display("FAIL ras_pop%0d: got pc=%h flags=%b required pc=%h flags=%b", j, pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
      else n_pass++;
    end
    quiet_reset();
    drive(0, 1, 0, 1, 0, 0, {OP_JR, 26'h0}, 32'h08);
    exp_q.push_back('{pc: 32'h08, oob: 0, empty: 1, full: 0, err: 1});
    @(posedge clkin); #1;
    e = exp_q.pop_front(); n_chk++;
    if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
      $display("FAIL ras_underflow: got pc=%h flags=%b required pc=%h flags=%b", pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
    else n_pass++;
    idle();
  endtask

  task automatic test_window();
    quiet_reset();
    for (int i = 1; i <= 36; i++) begin
      case (i)
        34: drive(0, 1, 0, 0, 0, 0, {OP_JR, 26'h0}, 32'h22);
        35: drive(0, 1, 1, 0, 0, 0, {OP_JAL, 26'h40}, 32'h0);
        36: drive(0, 1, 0, 1, 0, 0, {OP_JR, 26'h0}, 32'h22);
        default: idle();
      endcase
      if (i <= 31)      exp_q.push_back('{pc: 32'(4*i), oob: 0, empty: 1, full: 0, err: 0});
      else if (i == 32) exp_q.push_back('{pc: 32'h0, oob: 1, empty: 1, full: 0, err: 0});
      else if (i == 33) exp_q.push_back('{pc: 32'h4, oob: 0, empty: 1, full: 0, err: 0});
      else if (i == 34) exp_q.push_back('{pc: 32'h0, oob: 1, empty: 1, full: 0, err: 0});
      else if (i == 35) exp_q.push_back('{pc: 32'h0, oob: 1, empty: 0, full: 0, err: 0});
      else              exp_q.push_back('{pc: 32'h4, oob: 0, empty: 1, full: 0, err: 0});
      @(posedge clkin); #1;
      e = exp_q.pop_front(); n_chk++;
      if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
        $display("FAIL window%0d: got pc=%h flags=%b required pc=%h flags=%b", i, pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_stall();
    quiet_reset();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(0, 1, 0, 0, 0, 0, {OP_JR, 26'h0}, 32'h22);
        1, 2, 3: drive(1, 1, 1, 0, 0, 0, {OP_JAL, 26'h10}, 32'h0);
        4: drive(0, 1, 1, 0, 0, 0, {OP_JAL, 26'h10}, 32'h0);
        default: idle();
      endcase
      if (i == 0)      exp_q.push_back('{pc: 32'h0, oob: 1, empty: 1, full: 0, err: 0});
      else if (i <= 3) exp_q.push_back('{pc: 32'h0, oob: 0, empty: 1, full: 0, err: 0});
      else if (i == 4) exp_q.push_back('{pc: 32'h40, oob: 0, empty: 0, full: 0, err: 0});
      else             exp_q.push_back('{pc: 32'h44, oob: 0, empty: 0, full: 0, err: 0});
      @(posedge clkin); #1;
      e = exp_q.pop_front(); n_chk++;
      if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
        $display("FAIL stall%0d: got pc=%h flags=%b required pc=%h flags=%b", i, pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
      else n_pass++;
    end
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    #3;
    reset = 1'b1;
    exp_q.push_back('{pc: 32'h0, oob: 0, empty: 1, full: 0, err: 0});
    #2;
    e = exp_q.pop_front(); n_chk++;
    if ({pc_addr, oob, ras_empty, ras_full, ras_err} !== e)
      $display("FAIL stall_reset: got pc=%h flags=%b required pc=%h flags=%b", pc_addr, {oob, ras_empty, ras_full, ras_err}, e.pc, {e.oob, e.empty, e.full, e.err});
    else n_pass++;
    reset = 1'b0;
    idle();
  endtask

  initial begin
    #2;
    reset = 1'b0;
    @(posedge clkin); #1;
    test_reset();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_window();
    test_stall();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
